// File: rtl/reset_pulse_gen.sv
// Reset pulse generator: drives an active-low reset for PULSE_WIDTH cycles, waits for ready_in, then holds off.
// Optional macro RESET_PULSE_GEN_TIMEOUT_EN adds a WAIT_LIMIT watchdog on the ready wait (timed_out pulse).
module reset_pulse_gen #(
    parameter int PULSE_WIDTH = 16,
    parameter int WAIT_LIMIT  = 1000,
    parameter int HOLDOFF     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready_in,
    output logic resetn_out,
    output logic busy,
    output logic done,
    output logic timed_out
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_READY,
        HOLD
    } state_t;

    // HOLD always occupies at least one cycle, so HOLDOFF=0 still returns to IDLE on the next cycle
    localparam logic [15:0] PW_LOAD = 16'(PULSE_WIDTH - 1);
    localparam logic [15:0] HO_LOAD = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);

    if (PULSE_WIDTH < 1 || PULSE_WIDTH > 65535) begin : g_bad_pulse_width
        $error("reset_pulse_gen: PULSE_WIDTH out of range 1..65535");
    end
    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 65535) begin : g_bad_wait_limit
        $error("reset_pulse_gen: WAIT_LIMIT out of range 1..65535");
    end
    if (HOLDOFF < 0 || HOLDOFF > 255) begin : g_bad_holdoff
        $error("reset_pulse_gen: HOLDOFF out of range 0..255");
    end

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        resetn_q;
    logic        done_q;

`ifdef RESET_PULSE_GEN_TIMEOUT_EN
    localparam logic [15:0] WL_LOAD = 16'(WAIT_LIMIT - 1);

    logic timed_out_q;

    // Counter only ever decrements from a nonzero value, so it cannot wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            resetn_q    <= 1'b1;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q  <= ASSERT;
                        cnt_q    <= PW_LOAD;
                        resetn_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (cnt_q == 16'd0) begin
                        state_q  <= WAIT_READY;
                        cnt_q    <= WL_LOAD;
                        resetn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                WAIT_READY: begin
                    if (ready_in) begin
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                        cnt_q   <= HO_LOAD;
                    end else if (cnt_q == 16'd0) begin
                        timed_out_q <= 1'b1;
                        state_q     <= HOLD;
                        cnt_q       <= HO_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timed_out = timed_out_q;
`else
    // Without the watchdog the ready wait is unbounded and the counter is left untouched there
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            resetn_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q  <= ASSERT;
                        cnt_q    <= PW_LOAD;
                        resetn_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (cnt_q == 16'd0) begin
                        state_q  <= WAIT_READY;
                        resetn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                WAIT_READY: begin
                    if (ready_in) begin
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                        cnt_q   <= HO_LOAD;
                    end
                end
                HOLD: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timed_out = 1'b0;
`endif

    assign resetn_out = resetn_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule
